// File: rtl/div7_frame_sync.sv
// Frame synchronizer: locks onto a divide-by-7 frame clock, checks its period,
// and deserializes the din stream into 7-bit codewords on each accepted boundary.
module div7_frame_sync #(
    parameter int PERIOD   = 7,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       div_clk_in,
    input  logic       din,
    output logic       locked,
    output logic       frame_strobe,
    output logic [2:0] bit_idx,
    output logic [6:0] word_out,
    output logic       word_valid,
    output logic       period_err
);
    localparam logic [3:0] P_GOOD = 4'(PERIOD);
    localparam logic [3:0] P_TOUT = 4'(2 * PERIOD);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t     r_state;
    logic       r_sync1, r_sync2, r_sync3;
    logic [3:0] r_cnt;
    logic [3:0] r_good_cnt;
    logic [3:0] r_bad_cnt;
    logic [6:0] r_sr;
    logic [6:0] r_word;
    logic [2:0] r_bit_idx;
    logic       r_locked, r_fs, r_wv, r_pe;

    logic       w_rise, w_good, w_timeout;

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_good    = w_rise & (r_cnt == P_GOOD);
    // A rise in the timeout cycle wins: the period is judged, not timed out.
    assign w_timeout = ~w_rise & (r_cnt == P_TOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_cnt   <= 4'd0;
            r_sr    <= 7'd0;
        end else begin
            r_sync1 <= div_clk_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_sr    <= {r_sr[5:0], din};
            if (w_rise)
                r_cnt <= 4'd1;
            else if (r_cnt != 4'hF)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SEARCH;
            r_good_cnt <= 4'd0;
            r_bad_cnt  <= 4'd0;
            r_word     <= 7'd0;
            r_bit_idx  <= 3'd0;
            r_locked   <= 1'b0;
            r_fs       <= 1'b0;
            r_wv       <= 1'b0;
            r_pe       <= 1'b0;
        end else begin
            r_fs      <= 1'b0;
            r_wv      <= 1'b0;
            r_pe      <= 1'b0;
            r_bit_idx <= 3'd0;
            case (r_state)
                SEARCH: begin
                    if (w_rise) begin
                        r_state    <= VERIFY;
                        r_good_cnt <= 4'd0;
                    end
                end
                VERIFY: begin
                    if (w_rise) begin
                        if (w_good) begin
                            r_good_cnt <= r_good_cnt + 4'd1;
                            if (r_good_cnt + 4'd1 == LOCK_C) begin
                                r_state   <= LOCKED;
                                r_locked  <= 1'b1;
                                r_bad_cnt <= 4'd0;
                            end
                        end else begin
                            r_good_cnt <= 4'd0;
                        end
                    end else if (w_timeout) begin
                        r_state <= SEARCH;
                    end
                end
                LOCKED: begin
                    r_bit_idx <= (r_bit_idx == 3'd6) ? 3'd6 : r_bit_idx + 3'd1;
                    if (w_rise) begin
                        // Word captured includes this cycle's din bit as its LSB.
                        r_fs      <= 1'b1;
                        r_wv      <= 1'b1;
                        r_word    <= {r_sr[5:0], din};
                        r_bit_idx <= 3'd0;
                        if (w_good) begin
                            r_bad_cnt <= 4'd0;
                        end else begin
                            r_pe      <= 1'b1;
                            r_bad_cnt <= r_bad_cnt + 4'd1;
                            if (r_bad_cnt + 4'd1 == LOSS_C) begin
                                r_state  <= SEARCH;
                                r_locked <= 1'b0;
                            end
                        end
                    end else if (w_timeout) begin
                        r_pe      <= 1'b1;
                        r_state   <= SEARCH;
                        r_locked  <= 1'b0;
                        r_bit_idx <= 3'd0;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked       = r_locked;
    assign frame_strobe = r_fs;
    assign word_valid   = r_wv;
    assign period_err   = r_pe;
    assign word_out     = r_word;
    assign bit_idx      = r_bit_idx;
endmodule

// File: tb/tb_div7_frame_sync.sv
// Randomized bench for div7_frame_sync: a frame-level reference model predicts
// every cycle's outputs into a scoreboard that a separate monitor drains.
module tb_div7_frame_sync;
    localparam int PERIOD   = 7;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int MAXT     = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_clk_in = 1'b0;
    logic       din = 1'b0;
    logic       locked, frame_strobe, word_valid, period_err;
    logic [2:0] bit_idx;
    logic [6:0] word_out;

    div7_frame_sync #(.PERIOD(PERIOD), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .div_clk_in(div_clk_in), .din(din),
        .locked(locked), .frame_strobe(frame_strobe), .bit_idx(bit_idx),
        .word_out(word_out), .word_valid(word_valid), .period_err(period_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       fs;
        logic       wv;
        logic       pe;
        logic [2:0] bi;
        logic [6:0] w;
    } st_t;

    st_t        exp_q[$];
    logic [6:0] word_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model state: sample history per clock edge plus frame status.
    logic       vh[MAXT];
    logic       dh[MAXT];
    int         t = 0;
    int         rst_edge = 0;
    int         m_ref = 1;
    int         m_state = 0;  // 0 search, 1 verify, 2 locked
    int         m_g = 0;
    int         m_b = 0;
    logic [6:0] m_word = '0;
    int         m_bi = 0;
    logic [6:0] patv = 7'b1011001;

    function automatic logic vget(int i);
        if (i <= rst_edge || i < 1) return 1'b0;
        return vh[i];
    endfunction

    function automatic logic dget(int i);
        if (i <= rst_edge || i < 1) return 1'b0;
        return dh[i];
    endfunction

    task automatic model_step(input logic rn, input logic dv, input logic dn);
        st_t  e;
        logic r, gd, to, was_locked;
        int   p;
        t++;
        vh[t] = dv;
        dh[t] = dn;
        e = '0;
        if (!rn) begin
            rst_edge = t; m_ref = t + 1; m_state = 0;
            m_g = 0; m_b = 0; m_word = '0; m_bi = 0;
            exp_q.push_back(e);
            return;
        end
        // A frame edge is seen two edges after div_clk_in is first sampled high.
        r  = vget(t - 2) & ~vget(t - 3);
        p  = t - m_ref;
        if (p > 15) p = 15;
        gd = r && (p == PERIOD);
        to = !r && (p == 2 * PERIOD);
        was_locked = (m_state == 2);
        if (m_state == 0) begin
            if (r) begin m_state = 1; m_g = 0; end
        end else if (m_state == 1) begin
            if (r && gd) begin
                m_g++;
                if (m_g == LOCK_CNT) begin m_state = 2; m_b = 0; end
            end else if (r) m_g = 0;
            else if (to) m_state = 0;
        end else begin
            if (r) begin
                e.fs = 1'b1; e.wv = 1'b1;
                for (int k = 0; k < 7; k++) m_word[6-k] = dget(t - 6 + k);
                if (gd) m_b = 0;
                else begin
                    e.pe = 1'b1; m_b++;
                    if (m_b == LOSS_CNT) m_state = 0;
                end
            end else if (to) begin
                e.pe = 1'b1; m_state = 0;
            end
        end
        if (r) m_ref = t;
        if (m_state != 2 || r || !was_locked) m_bi = 0;
        else if (m_bi < 6) m_bi++;
        e.lk = (m_state == 2);
        e.bi = 3'(m_bi);
        e.w  = m_word;
        exp_q.push_back(e);
        if (e.wv) word_q.push_back(m_word);
    endtask

    task automatic tick(input logic rn, input logic dv, input logic dn);
        @(negedge clk);
        rst_n = rn; div_clk_in = dv; din = dn;
        model_step(rn, dv, dn);
    endtask

    task automatic per(input int len, input bit pat);
        logic dn;
        for (int k = 0; k < len; k++) begin
            dn = pat ? patv[6 - ((k + 4) % 7)] : 1'($urandom % 2);
            tick(1'b1, (k < 3), dn);
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one status record per clock edge, one word per word_valid pulse.
    st_t        mon_e, mon_a;
    logic [6:0] mon_w;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {locked, frame_strobe, word_valid, period_err, bit_idx, word_out};
                n_cmp++;
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL status @%0t: got lk=%b fs=%b wv=%b pe=%b bi=%0d w=%b expected lk=%b fs=%b wv=%b pe=%b bi=%0d w=%b",
                             $time, mon_a.lk, mon_a.fs, mon_a.wv, mon_a.pe, mon_a.bi, mon_a.w,
                             mon_e.lk, mon_e.fs, mon_e.wv, mon_e.pe, mon_e.bi, mon_e.w);
                end
            end
            if (word_valid === 1'b1) begin
                n_cmp++;
                if (word_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL word: got unexpected word %b at %0t expected none", word_out, $time);
                end else begin
                    mon_w = word_q.pop_front();
                    if (word_out !== mon_w) begin
                        n_bad++;
                        $display("FAIL word @%0t: got %b expected %b", $time, word_out, mon_w);
                    end
                end
            end
        end
    end

    initial begin
        int r, len;
        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        chk("reset_locked", locked, 0);
        chk("reset_word", word_out, 0);
        chk("reset_bidx", bit_idx, 0);
        // Clean acquisition: locked only after the 4th rise
        for (int i = 0; i < 3; i++) per(7, 1'b0);
        chk("acq_not_yet", locked, 0);
        per(7, 1'b0);
        chk("acq_locked", locked, 1);
        // Aligned codeword pattern
        for (int i = 0; i < 5; i++) per(7, 1'b1);
        chk("pattern_word", word_out, 7'b1011001);
        // One bad period keeps lock, two consecutive drop it
        per(8, 1'b0);
        per(6, 1'b0);
        chk("one_bad_locked", locked, 1);
        per(7, 1'b0);
        chk("two_bad_lost", locked, 0);
        for (int i = 0; i < 4; i++) per(7, 1'b0);
        chk("relock", locked, 1);
        // Timeout while locked; word held
        for (int i = 0; i < 2; i++) per(7, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'($urandom % 2));
        chk("timeout_lost", locked, 0);
        chk("timeout_word_held", word_out, 7'b1011001);
        // VERIFY with one bad period
        per(7, 1'b0); per(7, 1'b0); per(9, 1'b0);
        per(7, 1'b0); per(7, 1'b0); per(7, 1'b0);
        chk("verify_not_yet", locked, 0);
        per(7, 1'b0);
        chk("verify_locked", locked, 1);
        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'($urandom % 2));
        tick(1'b0, 1'b1, 1'b0);
        #1;
        chk("async_locked", locked, 0);
        chk("async_word", word_out, 0);
        chk("async_bidx", bit_idx, 0);
        chk("async_wv", word_valid, 0);
        for (int i = 0; i < 4; i++) per(7, 1'b0);
        chk("reset_relock", locked, 1);
        // Randomized periods, glitch bursts and short resets
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                for (int k = 0; k <= int'($urandom % 2); k++) tick(1'b0, 1'($urandom % 2), 1'($urandom % 2));
            end else if (r < 12) begin
                for (int k = 0; k < 6; k++) tick(1'b1, 1'($urandom % 2), 1'($urandom % 2));
            end else begin
                len = (r < 60) ? 7 : int'($urandom_range(4, 16));
                per(len, r[0]);
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("status_queue_drained", exp_q.size(), 0);
        chk("word_queue_drained", word_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div7_frame_sync.md
DIV7_FRAME_SYNC -- requirements
Module: div7_frame_sync

Interface
REQ-001 SHALL have parameter PERIOD, default 7: expected cycles of clk between consecutive rising edges of div_clk_in.
REQ-002 SHALL have parameter LOCK_CNT, default 3: consecutive good periods needed to enter LOCKED.
REQ-003 SHALL have parameter LOSS_CNT, default 2: consecutive bad periods in LOCKED that force SEARCH.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 div_clk_in  input  1  divided frame clock from the divide-by-7 block; may be glitchy or asynchronous.
REQ-007 din  input  1  serial codeword bit stream, one bit per clk cycle.
REQ-008 locked  output  1  high while the FSM is in LOCKED.
REQ-009 frame_strobe  output  1  one-cycle pulse per accepted frame boundary.
REQ-010 bit_idx  output  3  position within the current frame, 0..6.
REQ-011 word_out  output  7  last deserialized codeword; the earliest-received bit is the MSB.
REQ-012 word_valid  output  1  one-cycle pulse when word_out updates.
REQ-013 period_err  output  1  one-cycle pulse on a bad period or timeout while LOCKED.

Function
REQ-014 div_clk_in SHALL pass through a 2-flop synchronizer, then a third flop; rise = sync2 & ~sync3, an internal single-cycle pulse.
REQ-015 A 4-bit period counter SHALL clear to 1 on a rise cycle, else increment, saturating at 15.
REQ-016 On a rise, the period SHALL be good iff the counter value before clearing equals PERIOD, else bad.
REQ-017 Timeout SHALL occur when the counter reaches 2*PERIOD with no rise; a rise and timeout in the same cycle SHALL be treated as a rise only.
REQ-018 FSM states SHALL be SEARCH, VERIFY, LOCKED; reset state SEARCH.
REQ-019 SEARCH: the first rise SHALL move to VERIFY with good_cnt=0.
REQ-020 VERIFY: on a good rise, good_cnt SHALL increment and move to LOCKED when good_cnt reaches LOCK_CNT.
REQ-021 VERIFY: a bad rise SHALL clear good_cnt and stay in VERIFY; a timeout SHALL go to SEARCH.
REQ-022 LOCKED: a good rise SHALL clear bad_cnt.
REQ-023 LOCKED: a bad rise SHALL increment bad_cnt and pulse period_err, moving to SEARCH when bad_cnt reaches LOSS_CNT.
REQ-024 LOCKED: a timeout SHALL pulse period_err and go to SEARCH immediately.
REQ-025 A 7-bit shift register SHALL shift in din every cycle in every state: sr <= {sr[5:0], din}.
REQ-026 If a rise occurs at cycle T and the FSM is LOCKED at T, then in cycle T+1 frame_strobe=1, word_valid=1, and word_out = sr from T, i.e. din sampled at T-6..T, MSB = T-6.
REQ-027 A rise in the cycle that makes the LOCKED transition SHALL NOT produce word_valid; the first word SHALL come at the next rise.
REQ-028 word_out SHALL hold its value between word_valid pulses, including after loss of lock.
REQ-029 bit_idx SHALL be 0 in cycle T+1 after a rise, then increment each cycle and saturate at 6; it SHALL be forced to 0 whenever locked=0.
REQ-030 All outputs SHALL be registered; none SHALL be combinational from inputs.

Reset
REQ-031 rst_n=0 SHALL immediately clear the synchronizer, counters, sr, and word_out to 0, with FSM=SEARCH and all outputs 0.
REQ-032 Deassertion of rst_n mid-frame SHALL restart acquisition from SEARCH; reset-released flops SHALL NOT produce a rise unless div_clk_in is high for 2 synchronized samples after the low state.

Verification
REQ-033 Drive a clean div_clk_in with period 7 from reset -> locked=1 after the 4th rise (1st plus LOCK_CNT=3 good), with no frame_strobe before that.
REQ-034 When LOCKED, drive din with repeating pattern 1011001 aligned to rise -> word_out=7'b1011001 with word_valid each 7 cycles, and bit_idx sequencing 0,1,...,6.
REQ-035 When LOCKED, inject one period of 8 -> single period_err pulse, locked stays 1; a second consecutive period of 6 -> second period_err, locked=0 (SEARCH).
REQ-036 When LOCKED, hold div_clk_in low -> period_err pulse and locked=0 when the counter hits 14; word_out retains its last value.
REQ-037 In VERIFY, use periods 7,7,9,7,7,7 -> good_cnt clears at the 9, then locked=1 only after three further good periods.
REQ-038 Assert rst_n=0 for 1 cycle while LOCKED mid-frame -> all outputs 0 asynchronously, then re-lock after 4 rises.
